// File: rtl/fetch_pc_gen_pkg.sv
// Shared types for the fetch PC generator; supplies ADDR_WIDTH / FETCH_FIFO_DEPTH defaults
// when no defines.vh has set them.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef FETCH_FIFO_DEPTH
`define FETCH_FIFO_DEPTH 4
`endif

package fetch_pc_gen_pkg;
  localparam int AW      = `ADDR_WIDTH;
  localparam int ENTRY_W = 2*AW + 1;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [AW-1:0] pred_next;
    logic          hit;
  } pred_entry_t;

  // Sequential successor; wraps modulo 2^AW.
  function automatic logic [AW-1:0] pc_inc(input logic [AW-1:0] p);
    return p + {{(AW-1){1'b0}}, 1'b1};
  endfunction
endpackage

// File: rtl/fetch_pc_gen_pred_fifo.sv
// In-flight prediction FIFO; zero-latency head, clear beats push/pop.
// A push is accepted when not full, or when full with a simultaneous pop.
module pred_fifo
  import fetch_pc_gen_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        clear,
  input  pred_entry_t push_dat,
  output logic        full,
  output logic        empty,
  output pred_entry_t head_dat
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  pred_entry_t   mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign head_dat = mem_q[head_q];
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) tail_d = tail_q + PW'(1);
      if (pop_ok)  head_d = head_q + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem_q[tail_q] <= push_dat;
  end
endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: table-driven next-PC, in-flight check, redirect/flush and table training.
// Optional FETCH_PRED_STATS_EN adds saturating resolve / mispredict counters.
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter int            DEPTH    = `FETCH_FIFO_DEPTH,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  output logic [AW-1:0] pc,
  output logic          pc_valid,
  output logic [AW-1:0] pred_next,
  output logic [AW-1:0] lut_read_key,
  input  logic [AW-1:0] lut_read_val,
  input  logic          lut_read_valid,
  input  logic          resolve_valid,
  input  logic          resolve_taken,
  input  logic [AW-1:0] resolve_target,
  output logic          flush,
  output logic          lut_write,
  output logic [AW-1:0] lut_write_key,
  output logic [AW-1:0] lut_write_val
`ifdef FETCH_PRED_STATS_EN
  ,
  output logic [31:0]   resolve_count,
  output logic [31:0]   mispredict_count
`endif
);
  logic [AW-1:0] pc_q, pc_d;
  logic          flush_q, flush_d;
  logic          lut_write_q, lut_write_d;
  logic [AW-1:0] lut_write_key_q, lut_write_key_d;
  logic [AW-1:0] lut_write_val_q, lut_write_val_d;
  logic [AW-1:0] actual;
  logic          fifo_full, fifo_empty, pop, fire, mispredict;
  pred_entry_t   head, push_dat;

  assign pred_next    = lut_read_valid ? lut_read_val : pc_inc(pc_q);
  assign lut_read_key = pc_q;
  assign actual       = resolve_taken ? resolve_target : pc_inc(head.pc);
  assign pop          = resolve_valid && !fifo_empty;
  assign mispredict   = pop && (actual != head.pred_next);
  assign fire         = !stall && !mispredict && (!fifo_full || pop);
  assign push_dat     = '{pc: pc_q, pred_next: pred_next, hit: lut_read_valid};

  pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (reset),
    .push     (fire),
    .pop      (pop),
    .clear    (mispredict),
    .push_dat (push_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head_dat (head)
  );

  always_comb begin
    pc_d            = pc_q;
    lut_write_key_d = lut_write_key_q;
    lut_write_val_d = lut_write_val_q;
    if (mispredict)  pc_d = actual;
    else if (fire)   pc_d = pred_next;
    flush_d     = mispredict;
    // Train on taken branches the table missed or pointed elsewhere.
    lut_write_d = pop && resolve_taken && (!head.hit || head.pred_next != resolve_target);
    if (lut_write_d) begin
      lut_write_key_d = head.pc;
      lut_write_val_d = resolve_target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q            <= RESET_PC;
      flush_q         <= 1'b0;
      lut_write_q     <= 1'b0;
      lut_write_key_q <= '0;
      lut_write_val_q <= '0;
    end else begin
      pc_q            <= pc_d;
      flush_q         <= flush_d;
      lut_write_q     <= lut_write_d;
      lut_write_key_q <= lut_write_key_d;
      lut_write_val_q <= lut_write_val_d;
    end
  end

  assign pc            = pc_q;
  assign pc_valid      = fire;
  assign flush         = flush_q;
  assign lut_write     = lut_write_q;
  assign lut_write_key = lut_write_key_q;
  assign lut_write_val = lut_write_val_q;

`ifdef FETCH_PRED_STATS_EN
  logic [31:0] resolve_count_q, resolve_count_d;
  logic [31:0] mispredict_count_q, mispredict_count_d;

  always_comb begin
    resolve_count_d    = resolve_count_q;
    mispredict_count_d = mispredict_count_q;
    if (pop && resolve_count_q != '1)           resolve_count_d    = resolve_count_q + 32'd1;
    if (mispredict && mispredict_count_q != '1) mispredict_count_d = mispredict_count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resolve_count_q    <= '0;
      mispredict_count_q <= '0;
    end else begin
      resolve_count_q    <= resolve_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign resolve_count    = resolve_count_q;
  assign mispredict_count = mispredict_count_q;
`endif
endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen with 16-bit addresses and a 4-entry FIFO.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
module tb_fetch_pc_gen;
  logic        clk = 1'b0;
  logic        reset, stall, lut_read_valid, resolve_valid, resolve_taken;
  logic [15:0] lut_read_val, resolve_target;
  logic [15:0] pc, pred_next, lut_read_key, lut_write_key, lut_write_val;
  logic        pc_valid, flush, lut_write;
`ifdef FETCH_PRED_STATS_EN
  logic [31:0] resolve_count, mispredict_count;
`endif
  int checks = 0;
  int errors = 0;

  fetch_pc_gen #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .pc(pc), .pc_valid(pc_valid),
    .pred_next(pred_next), .lut_read_key(lut_read_key), .lut_read_val(lut_read_val),
    .lut_read_valid(lut_read_valid), .resolve_valid(resolve_valid),
    .resolve_taken(resolve_taken), .resolve_target(resolve_target), .flush(flush),
    .lut_write(lut_write), .lut_write_key(lut_write_key), .lut_write_val(lut_write_val)
`ifdef FETCH_PRED_STATS_EN
    , .resolve_count(resolve_count), .mispredict_count(mispredict_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; lut_read_valid = 0; lut_read_val = 0;
    resolve_valid = 0; resolve_taken = 0; resolve_target = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    #1;
    checks++; if (pc !== 16'h0) begin errors++; $display("FAIL reset_pc got %h want 0000", pc); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b want 0", flush); end
    checks++; if (lut_write !== 1'b0 || lut_write_key !== 16'h0 || lut_write_val !== 16'h0) begin
      errors++; $display("FAIL reset_write got %b/%h/%h want 0/0000/0000", lut_write, lut_write_key, lut_write_val); end
    checks++; if (dut.u_fifo.count_q !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", dut.u_fifo.count_q); end
    step();
    reset = 0;
    #1;
  endtask

  task automatic test_fill_full();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      checks++; if (pc !== 16'(i) || pc_valid !== 1'b1) begin
        errors++; $display("FAIL fill_%0d got pc=%h vld=%b want pc=%h vld=1", i, pc, pc_valid, 16'(i)); end
      step();
    end
    checks++; if (pc !== 16'h4 || pc_valid !== 1'b0 || dut.u_fifo.count_q !== 3'd4) begin
      errors++; $display("FAIL full_stall got pc=%h vld=%b cnt=%0d want 0004/0/4", pc, pc_valid, dut.u_fifo.count_q); end
    step();
    checks++; if (pc !== 16'h4) begin errors++; $display("FAIL full_hold got %h want 0004", pc); end
    resolve_valid = 1; resolve_taken = 0;
    #1;
    checks++; if (pc_valid !== 1'b1) begin errors++; $display("FAIL full_pop_fire got %b want 1", pc_valid); end
    step();
    resolve_valid = 0;
    checks++; if (pc !== 16'h5 || dut.u_fifo.count_q !== 3'd4 || flush !== 1'b0) begin
      errors++; $display("FAIL full_pop_push got pc=%h cnt=%0d fl=%b want 0005/4/0", pc, dut.u_fifo.count_q, flush); end
    stall = 1; resolve_valid = 1;
    #1;
    checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL stall_vld got %b want 0", pc_valid); end
    step();
    resolve_valid = 0;
    checks++; if (pc !== 16'h5 || dut.u_fifo.count_q !== 3'd3 || flush !== 1'b0) begin
      errors++; $display("FAIL stall_pop got pc=%h cnt=%0d fl=%b want 0005/3/0", pc, dut.u_fifo.count_q, flush); end
  endtask

  task automatic test_hit_not_taken();
    apply_reset();
    step(); step(); step();
    lut_read_valid = 1; lut_read_val = 16'h0020;
    #1;
    checks++; if (pred_next !== 16'h0020 || lut_read_key !== 16'h0003) begin
      errors++; $display("FAIL hit_pred got next=%h key=%h want 0020/0003", pred_next, lut_read_key); end
    step();
    lut_read_valid = 0;
    checks++; if (pc !== 16'h0020 || dut.u_fifo.count_q !== 3'd4) begin
      errors++; $display("FAIL hit_pc got pc=%h cnt=%0d want 0020/4", pc, dut.u_fifo.count_q); end
    stall = 1; resolve_valid = 1; resolve_taken = 0;
    step(); step(); step();
    checks++; if (dut.u_fifo.count_q !== 3'd1 || flush !== 1'b0) begin
      errors++; $display("FAIL hit_drain got cnt=%0d fl=%b want 1/0", dut.u_fifo.count_q, flush); end
    stall = 0;
    #1;
    checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL mispredict_suppress got %b want 0", pc_valid); end
    step();
    resolve_valid = 0;
    checks++; if (flush !== 1'b1 || pc !== 16'h0004 || dut.u_fifo.count_q !== 3'd0 || lut_write !== 1'b0) begin
      errors++; $display("FAIL stale_hit got fl=%b pc=%h cnt=%0d wr=%b want 1/0004/0/0", flush, pc, dut.u_fifo.count_q, lut_write); end
    step();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL flush_pulse got %b want 0", flush); end
  endtask

  task automatic test_miss_taken();
    apply_reset();
    lut_read_valid = 1; lut_read_val = 16'h0010;
    step();
    lut_read_valid = 0;
    step();
    checks++; if (pc !== 16'h0011 || dut.u_fifo.count_q !== 3'd2) begin
      errors++; $display("FAIL miss_setup got pc=%h cnt=%0d want 0011/2", pc, dut.u_fifo.count_q); end
    stall = 1; resolve_valid = 1; resolve_taken = 1; resolve_target = 16'h0010;
    step();
    checks++; if (flush !== 1'b0 || lut_write !== 1'b0 || dut.u_fifo.count_q !== 3'd1) begin
      errors++; $display("FAIL hit_match got fl=%b wr=%b cnt=%0d want 0/0/1", flush, lut_write, dut.u_fifo.count_q); end
    resolve_target = 16'h0040;
    step();
    resolve_valid = 0;
    checks++; if (flush !== 1'b1 || pc !== 16'h0040 || dut.u_fifo.count_q !== 3'd0) begin
      errors++; $display("FAIL miss_taken_redirect got fl=%b pc=%h cnt=%0d want 1/0040/0", flush, pc, dut.u_fifo.count_q); end
    checks++; if (lut_write !== 1'b1 || lut_write_key !== 16'h0010 || lut_write_val !== 16'h0040) begin
      errors++; $display("FAIL miss_taken_train got %b/%h/%h want 1/0010/0040", lut_write, lut_write_key, lut_write_val); end
    step();
    checks++; if (lut_write !== 1'b0 || flush !== 1'b0) begin
      errors++; $display("FAIL train_pulse got wr=%b fl=%b want 0/0", lut_write, flush); end
  endtask

  task automatic test_correct_predict();
    apply_reset();
    lut_read_valid = 1; lut_read_val = 16'h0010;
    step();
    lut_read_val = 16'h0040;
    step();
    lut_read_valid = 0;
    checks++; if (pc !== 16'h0040) begin errors++; $display("FAIL chain_hit got %h want 0040", pc); end
    step();
    stall = 1; resolve_valid = 1; resolve_taken = 1; resolve_target = 16'h0010;
    step();
    resolve_target = 16'h0040;
    step();
    checks++; if (flush !== 1'b0 || lut_write !== 1'b0 || dut.u_fifo.count_q !== 3'd1) begin
      errors++; $display("FAIL correct_pred got fl=%b wr=%b cnt=%0d want 0/0/1", flush, lut_write, dut.u_fifo.count_q); end
    resolve_target = 16'h0041;
    step();
    resolve_valid = 0;
    checks++; if (flush !== 1'b0 || lut_write !== 1'b1 || lut_write_key !== 16'h0040 ||
                  lut_write_val !== 16'h0041 || pc !== 16'h0041 || dut.u_fifo.count_q !== 3'd0) begin
      errors++; $display("FAIL miss_same_target got fl=%b wr=%b %h/%h pc=%h want 0/1 0040/0041 pc=0041",
                         flush, lut_write, lut_write_key, lut_write_val, pc); end
  endtask

  task automatic test_empty_resolve();
    apply_reset();
    stall = 1; resolve_valid = 1; resolve_taken = 1; resolve_target = 16'h0099;
    step();
    resolve_valid = 0;
    checks++; if (flush !== 1'b0 || lut_write !== 1'b0 || pc !== 16'h0 || dut.u_fifo.count_q !== 3'd0) begin
      errors++; $display("FAIL empty_resolve got fl=%b wr=%b pc=%h cnt=%0d want 0/0/0000/0",
                         flush, lut_write, pc, dut.u_fifo.count_q); end
`ifdef FETCH_PRED_STATS_EN
    checks++; if (resolve_count !== 32'd0) begin errors++; $display("FAIL empty_stats got %0d want 0", resolve_count); end
`endif
  endtask

  task automatic test_wrap_reset();
    apply_reset();
    lut_read_valid = 1; lut_read_val = 16'hFFFF;
    step();
    lut_read_valid = 0;
    #1;
    checks++; if (pc !== 16'hFFFF || pred_next !== 16'h0000) begin
      errors++; $display("FAIL wrap_pred got pc=%h next=%h want FFFF/0000", pc, pred_next); end
    step();
    checks++; if (pc !== 16'h0000 || dut.u_fifo.count_q !== 3'd2) begin
      errors++; $display("FAIL wrap_pc got pc=%h cnt=%0d want 0000/2", pc, dut.u_fifo.count_q); end
    stall = 1; resolve_valid = 1; resolve_taken = 1; resolve_target = 16'h0055;
    step();
    resolve_valid = 0;
    checks++; if (flush !== 1'b1 || lut_write !== 1'b1 || pc !== 16'h0055) begin
      errors++; $display("FAIL pre_reset got fl=%b wr=%b pc=%h want 1/1/0055", flush, lut_write, pc); end
    reset = 1;
    #1;
    checks++; if (flush !== 1'b0 || lut_write !== 1'b0 || pc !== 16'h0 ||
                  dut.u_fifo.count_q !== 3'd0 || lut_write_key !== 16'h0) begin
      errors++; $display("FAIL mid_reset got fl=%b wr=%b pc=%h cnt=%0d key=%h want 0/0/0000/0/0000",
                         flush, lut_write, pc, dut.u_fifo.count_q, lut_write_key); end
    step();
    reset = 0;
  endtask

  initial begin
    idle_inputs();
    reset = 0;
    test_reset();
    test_fill_full();
    test_hit_not_taken();
    test_miss_taken();
    test_correct_predict();
    test_empty_resolve();
    test_wrap_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
- Fetch-stage PC generator sitting directly upstream of the 8-entry PC->target lookup table.
- Drives the table's lookup key every cycle and chooses the next PC: the table target on a hit, otherwise PC+1.
- Keeps a FIFO of in-flight predictions and checks each one against branch resolutions from execute.
- On a mismatch it redirects fetch, raises a flush, and issues the table write that trains the lookup table.

Parameters:
- DEPTH, 4: in-flight prediction FIFO entries; power of 2, 2..16.
- RESET_PC, 0: PC value loaded on reset.
- Address width is `ADDR_WIDTH from defines.vh; it is not a parameter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- stall  in  1  decode back-pressure; no fetch fires while high.
- pc  out  ADDR_WIDTH  current fetch PC (registered).
- pc_valid  out  1  fetch fires this cycle.
- pred_next  out  ADDR_WIDTH  predicted next PC for the current pc (combinational).
- lut_read_key  out  ADDR_WIDTH  equals pc (combinational).
- lut_read_val  in  ADDR_WIDTH  target returned by the table.
- lut_read_valid  in  1  table hit.
- resolve_valid  in  1  execute resolves the oldest in-flight fetch.
- resolve_taken  in  1  resolved branch was taken.
- resolve_target  in  ADDR_WIDTH  resolved target (meaningful only when taken).
- flush  out  1  one-cycle pulse; younger stages discard in-flight work.
- lut_write  out  1  one-cycle write strobe to the table.
- lut_write_key  out  ADDR_WIDTH  PC being trained.
- lut_write_val  out  ADDR_WIDTH  target being trained.

Behaviour:
- Reset values (asynchronous, immediate): pc=RESET_PC; FIFO empty (head=tail=count=0); flush=0; lut_write=0; lut_write_key=0; lut_write_val=0.
- Prediction (combinational): pred_next = lut_read_valid ? lut_read_val : pc+1. The +1 wraps modulo 2^ADDR_WIDTH.
- mispredict (combinational) is asserted when resolve_valid, the FIFO is non-empty, and actual != head.pred_next.
  - actual = resolve_taken ? resolve_target : head.pc+1.
- pop = resolve_valid && count!=0.
- fire = !stall && !mispredict && (count<DEPTH || pop). pc_valid = fire.
- On fire:
  - FIFO pushes {pc, pred_next, lut_read_valid} at tail.
  - pc <= pred_next.
  - Fetch-to-push latency is 0 cycles; the FIFO entry is visible the next cycle.
- On pop without mispredict: head advances. Simultaneous push and pop leaves count unchanged.
- On mispredict, at the same clock edge:
  - pc <= actual.
  - FIFO is cleared (count=0, head=tail).
  - flush <= 1 for exactly one cycle.
  - Any fetch this cycle is suppressed (pc_valid=0).
- Table training, registered, one-cycle pulse the cycle after resolve:
  - lut_write <= 1 when pop && resolve_taken && (!head.hit || head.pred_next != resolve_target).
  - lut_write_key <= head.pc; lut_write_val <= resolve_target.
  - Not-taken resolutions never write; the table has no invalidate. A stale hit is corrected by flush only.
- resolve_valid with an empty FIFO is ignored: no pop, no flush, no write.
- stall high: pc holds and nothing is pushed; resolves still pop and can still flush.
- FIFO full with no pop: fetch stalls internally (pc_valid=0, pc holds).
- Reset asserted mid-operation: all state returns to reset values immediately; a pending flush or write pulse is dropped.

Optional Feature:
- Macro: FETCH_PRED_STATS_EN.
- When defined, adds two outputs:
  - resolve_count, 32 bits, increments on each pop.
  - mispredict_count, 32 bits, increments on each mispredict.
  - Both saturate at 2^32-1 and clear on reset.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Decomposition:
- defines.vh (shared): `ADDR_WIDTH; new `FETCH_FIFO_DEPTH default (4); entry field widths (pc, pred_next, hit = 2*ADDR_WIDTH+1 bits).
- Sub-module pred_fifo: synchronous FIFO of DEPTH entries.
  - Ports: push, pop, clear, full, empty, head data.
  - clear has priority over push and pop in the same cycle.
- fetch_pc_gen contains the PC register, prediction mux, compare logic and write-back registers.

Test Plan:
- Reset, no table hits, stall=0, resolve_valid=0: pc = 0,1,2,3 with pc_valid=1; cycle 5 pc_valid=0 (full, count=4).
- Hit: table returns valid 0x20 for pc=0x03 -> next pc=0x20; later not-taken resolve of 0x03 -> flush=1, pc=0x04, FIFO empty, lut_write=0.
- Miss then taken: pc=0x10 misses, resolve taken target 0x40 -> flush=1, pc=0x40; next cycle lut_write=1, key=0x10, val=0x40.
- Correct prediction: 0x10 hit with target 0x40, resolved taken 0x40 -> no flush, no write, count drops by 1.
- Full FIFO plus resolve (match) in the same cycle -> pc_valid=1, count stays 4; stall=1 with resolve -> pop only, pc holds.
- Wrap and reset: pc=0xFFFF (ADDR_WIDTH=16) miss -> next pc=0x0000; assert reset mid-flush -> flush=0, pc=RESET_PC, FIFO empty within the same cycle.
